// File: rtl/keymatrix_injector.sv
// Keystroke injector for the EG2000 keyboard matrix. Queued key codes are played
// out as timed press/hold/release events, ORed onto the physical column response.
`timescale 1ns/1ps
module keymatrix_injector #(
  parameter int unsigned DEPTH = 16,
  parameter logic [15:0] HOLD  = 16'd2000,
  parameter logic [15:0] GAP   = 16'd2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       abort,
  input  logic [7:0] a,
  input  logic [7:0] kq,
  output logic [7:0] q,
  output logic       full,
  output logic       busy,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PRESS, RELEASE} state_t;

  typedef struct packed {
    logic       shift;
    logic [2:0] row;
    logic [2:0] col;
  } key_t;

  key_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  state_t        state, state_d;
  key_t          entry, entry_d;
  logic          inj_on, inj_on_d;
  logic          inj_shift, inj_shift_d;
  logic [15:0]   timer, timer_d;

  // Bit 7 of a key code is reserved and deliberately dropped.
  logic unused_wdata;
  assign unused_wdata = wdata[7];

  // Fullness is judged on the registered count, so a same-cycle pop never makes room.
  assign full = (count == FULL_COUNT);
  assign push = wr & ~full & ~abort;
  assign pop  = (state == IDLE) & (count != '0) & ~abort;
  assign busy = (state != IDLE) | (count != '0);

  // NOTE: key storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= key_t'(wdata[6:0]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (wr && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      entry     <= '0;
      inj_on    <= 1'b0;
      inj_shift <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_d;
      entry     <= entry_d;
      inj_on    <= inj_on_d;
      inj_shift <= inj_shift_d;
      timer     <= timer_d;
    end
  end

  // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    entry_d     = entry;
    inj_on_d    = inj_on;
    inj_shift_d = inj_shift;
    timer_d     = timer;
    if (abort) begin
      state_d     = IDLE;
      inj_on_d    = 1'b0;
      inj_shift_d = 1'b0;
      timer_d     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            entry_d = mem[rd_ptr];
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (entry.shift) begin
            inj_shift_d = 1'b1;
            timer_d     = GAP - 16'd1;
            state_d     = SHIFT;
          end else begin
            inj_on_d = 1'b1;
            timer_d  = HOLD - 16'd1;
            state_d  = PRESS;
          end
        end
        SHIFT: begin
          if (ce) begin
            if (timer == '0) begin
              inj_on_d = 1'b1;
              timer_d  = HOLD - 16'd1;
              state_d  = PRESS;
            end else begin
              timer_d = timer - 16'd1;
            end
          end
        end
        PRESS: begin
          if (ce) begin
            if (timer == '0) begin
              inj_on_d    = 1'b0;
              inj_shift_d = 1'b0;
              timer_d     = GAP - 16'd1;
              state_d     = RELEASE;
            end else begin
              timer_d = timer - 16'd1;
            end
          end
        end
        RELEASE: begin
          if (ce) begin
            if (timer == '0) state_d = IDLE;
            else             timer_d = timer - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synthetic key and Shift simply OR onto the physical response.
  always_comb begin
    q = kq;
    if (inj_on && a[entry.row]) q[entry.col] = 1'b1;
    if (inj_shift && a[7])      q[0]         = 1'b1;
  end

endmodule

// File: tb/tb_keymatrix_injector.sv
// Self-checking bench for keymatrix_injector: directed timing checks plus a
// matrix-scanning monitor that scores random key streams against expected key events.
`timescale 1ns/1ps
module tb_keymatrix_injector;

  localparam int          DEPTH = 16;
  localparam logic [15:0] HOLD  = 16'd4;
  localparam logic [15:0] GAP   = 16'd3;

  logic       clock = 1'b0;
  logic       reset, ce, wr, abort;
  logic [7:0] wdata, a, a_dir, a_mon, kq, q;
  logic       full, busy, ovf;
  logic       mon_en = 1'b0;
  bit         rand_ce = 1'b0;

  always #10 clock = ~clock;
  assign a = mon_en ? a_mon : a_dir;

  keymatrix_injector #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .ce(ce), .wr(wr), .wdata(wdata), .abort(abort),
    .a(a), .kq(kq), .q(q), .full(full), .busy(busy), .ovf(ovf)
  );

  // One expected matrix event: the set of (row,col) keys visible, and for how many ce ticks.
  typedef struct {
    logic [63:0] bm;
    int          ticks;
  } run_t;

  run_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] key_bit(input logic [2:0] row, input logic [2:0] col);
    return 64'd1 << {row, col};
  endfunction

  // Reference: a shifted key shows Shift alone for GAP ticks, then Shift+key for HOLD ticks.
  task automatic expect_key(input logic [7:0] code);
    run_t r;
    logic [63:0] sh;
    sh = key_bit(3'd7, 3'd0);
    if (code[6]) begin
      r.bm = sh;
      r.ticks = int'(GAP);
      exp_q.push_back(r);
      r.bm = sh | key_bit(code[5:3], code[2:0]);
    end else begin
      r.bm = key_bit(code[5:3], code[2:0]);
    end
    r.ticks = int'(HOLD);
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accepted);
    wr = 1'b1;
    wdata = b;
    tick();
    wr = 1'b0;
    if (accepted) expect_key(b);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n >= budget), 64'd0);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: scans all eight rows each cycle, builds the synthetic key map, scores runs.
  logic [63:0] cur_bm;
  int          cur_ticks;
  bit          mon_on  = 1'b0;
  bit          seen_key;

  always @(negedge clock) begin
    logic [63:0] bm;
    run_t        e;
    if (!mon_en) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on) begin
        cur_bm    = '0;
        cur_ticks = 0;
        seen_key  = 1'b0;
        mon_on    = 1'b1;
      end
      bm = '0;
      for (int r = 0; r < 8; r++) begin
        a_mon = 8'(1 << r);
        #1;
        bm[r*8 +: 8] = q & ~kq;
      end
      if (bm != cur_bm) begin
        if (cur_bm != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_key", cur_bm, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("key_matrix", cur_bm, e.bm);
            check("key_ticks", 64'(cur_ticks), 64'(e.ticks));
          end
          seen_key = 1'b1;
        end else if (seen_key) begin
          check("release_gap_short", 64'(cur_ticks < int'(GAP)), 64'd0);
        end
        cur_bm    = bm;
        cur_ticks = 0;
      end
      if (ce) cur_ticks++;
    end
  end

  initial begin
    logic [7:0] b;
    int         occ;
    bit         dropped, pop_now, acc;

    reset = 1'b1; ce = 1'b1; wr = 1'b0; wdata = '0; abort = 1'b0;
    a_dir = 8'hFF; kq = 8'h00; a_mon = 8'h00;
    #5 reset = 1'b0;
    kq = 8'h5A;
    #1;
    check("reset_q", q, kq);
    check("reset_full", full, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    kq = 8'h00;
    tick();
    reset = 1'b1;
    tick();

    // Single unshifted key 'A' at row 0, col 1.
    write_byte(8'h01, 1'b0);
    tick();
    tick();
    for (int i = 0; i < int'(HOLD); i++) begin
      a_dir = 8'h01; #1; check("a_press_row0", q, 8'h02);
      a_dir = 8'h02; #1; check("a_press_row1", q, 8'h00);
      if (i == 1) begin
        kq = 8'h10; a_dir = 8'h01; #1; check("a_with_phys", q, 8'h12);
        kq = 8'h00;
      end
      tick();
    end
    for (int i = 0; i < int'(GAP); i++) begin
      a_dir = 8'hFF; #1;
      check("a_release_q", q, 8'h00);
      check("a_release_busy", busy, 1'b1);
      tick();
    end
    check("a_idle_busy", busy, 1'b0);

    // Shifted key: Shift leads, then Shift+key, both release together.
    write_byte(8'h45, 1'b0);
    tick();
    tick();
    for (int i = 0; i < int'(GAP); i++) begin
      a_dir = 8'h80; #1; check("sh_lead_shift", q, 8'h01);
      a_dir = 8'h01; #1; check("sh_lead_nokey", q, 8'h00);
      tick();
    end
    for (int i = 0; i < int'(HOLD); i++) begin
      a_dir = 8'h81; #1; check("sh_press", q, 8'h21);
      tick();
    end
    a_dir = 8'h81; #1; check("sh_release", q, 8'h00);
    repeat (int'(GAP)) tick();
    check("sh_idle_busy", busy, 1'b0);

    // Fill and overflow, scored by the monitor. Pops land at write cycles 1, 10, 19.
    a_dir = 8'hFF;
    mon_en = 1'b1;
    tick();
    occ = 0;
    dropped = 1'b0;
    for (int k = 0; k < 20; k++) begin
      b = 8'($urandom) & 8'hBF;
      pop_now = (k == 1) || (k == 10) || (k == 19);
      acc = (occ != DEPTH);
      write_byte(b, acc);
      occ = occ + int'(acc) - int'(pop_now);
      if (!acc) dropped = 1'b1;
      check("fill_full", full, 1'(occ == DEPTH));
      check("fill_ovf", ovf, dropped);
    end
    wait_idle(3000);
    check("fill_ovf_sticky", ovf, 1'b1);
    mon_en = 1'b0;
    tick();

    // Abort mid-press with five entries still queued; a same-cycle write is lost.
    for (int k = 0; k < 6; k++) write_byte(8'($urandom) & 8'hBF, 1'b0);
    check("abort_pre_busy", busy, 1'b1);
    check("abort_pre_ovf", ovf, 1'b1);
    abort = 1'b1; wr = 1'b1; wdata = 8'h12;
    tick();
    abort = 1'b0; wr = 1'b0;
    kq = 8'($urandom);
    #1;
    check("abort_q", q, kq);
    check("abort_busy", busy, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    check("abort_full", full, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      kq = 8'($urandom);
      a_dir = 8'($urandom);
      #1;
      check("abort_quiet_q", q, kq);
      check("abort_quiet_busy", busy, 1'b0);
    end

    // Asynchronous reset while in the Shift lead-in.
    kq = 8'h00; a_dir = 8'hFF;
    write_byte(8'h52, 1'b0);
    write_byte(8'h13, 1'b0);
    write_byte(8'h24, 1'b0);
    check("rst_in_shift", q, 8'h01);
    #3 reset = 1'b0;
    kq = 8'h3C;
    #1;
    check("rst_q", q, kq);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    kq = 8'h00;
    tick();

    // Random key streams with a random timebase enable.
    mon_en = 1'b1;
    rand_ce = 1'b1;
    tick();
    for (int burst = 0; burst < 8; burst++) begin
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        b = 8'($urandom);
        if (b[6] && b[5:3] == 3'd7 && b[2:0] == 3'd0) b[6] = 1'b0;
        write_byte(b, 1'b1);
        repeat ($urandom_range(0, 4)) tick();
      end
      wait_idle(3000);
    end
    check("rand_ovf", ovf, 1'b0);
    mon_en = 1'b0;
    rand_ce = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
